// File: rtl/riscv_core_dpath_pipe_muldiv_param.sv
// rtl/riscv_core_dpath_pipe_muldiv_param.sv - elastic parametrised mul/div pipeline
// Divider built only when RISCV_MULDIV_DIV_EN is defined; otherwise div/rem ops return err.
module riscv_core_dpath_pipe_muldiv_param #(
  parameter int W      = 32,
  parameter int STAGES = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [2:0]                   muldivreq_msg_fn,
  input  logic [W-1:0]                 muldivreq_msg_a,
  input  logic [W-1:0]                 muldivreq_msg_b,
  input  logic                         muldivreq_val,
  output logic                         muldivreq_rdy,
  output logic [2*W-1:0]               muldivresp_msg_result,
  output logic                         muldivresp_err,
  output logic                         muldivresp_val,
  input  logic                         muldivresp_rdy,
  input  logic                         flush,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int OW = $clog2(STAGES+1);
  localparam logic [2:0] FN_MUL   = 3'd0;
  localparam logic [2:0] FN_DIV   = 3'd1;
  localparam logic [2:0] FN_DIVU  = 3'd2;
  localparam logic [2:0] FN_REM   = 3'd3;
  localparam logic [2:0] FN_REMU  = 3'd4;
  localparam logic [2:0] FN_MULU  = 3'd5;
  localparam logic [2:0] FN_MULSU = 3'd6;

  logic [STAGES-1:0]             v_q, v_d, adv;
  logic [2:0]                    fn_q;
  logic [W-1:0]                  a_q, b_q;
  logic [STAGES-1:1][2*W-1:0]    res_q;
  logic [STAGES-1:1]             err_q;
  logic [2*W-1:0]                res_c, ea, eb, prod;
  logic                          err_c, accept;

  // A stage advances when any stage downstream of it is empty or the consumer takes the head.
  always_comb begin
    logic hole;
    hole = muldivresp_rdy;
    for (int i = STAGES-1; i >= 0; i--) begin
      adv[i] = hole;
      hole   = hole || !v_q[i];
    end
  end

  assign muldivreq_rdy = !flush && (!v_q[0] || adv[0]);
  assign accept        = muldivreq_val && muldivreq_rdy;

  always_comb begin
    v_d[0] = accept || (v_q[0] && !adv[0]);
    for (int i = 1; i < STAGES; i++)
      v_d[i] = (!v_q[i] || adv[i]) ? v_q[i-1] : v_q[i];
  end

  always_comb begin
    ea   = {{W{(fn_q != FN_MULU) && a_q[W-1]}}, a_q};
    eb   = {{W{(fn_q == FN_MUL) && b_q[W-1]}}, b_q};
    prod = ea * eb;
  end

`ifdef RISCV_MULDIV_DIV_EN
  logic         sgn, a_neg, b_neg;
  logic [W-1:0] ua, ub, uq, ur, q, r;
  // Signed overflow falls out of the magnitude path: |a|/1 negated is a again, remainder 0.
  always_comb begin
    sgn   = (fn_q == FN_DIV) || (fn_q == FN_REM);
    a_neg = sgn && a_q[W-1];
    b_neg = sgn && b_q[W-1];
    ua    = a_neg ? -a_q : a_q;
    ub    = b_neg ? -b_q : b_q;
    uq    = ua / ub;
    ur    = ua % ub;
    if (b_q == '0) begin
      q = '1;
      r = a_q;
    end else begin
      q = (a_neg ^ b_neg) ? -uq : uq;
      r = a_neg ? -ur : ur;
    end
  end
`endif

  always_comb begin
    res_c = '0;
    err_c = 1'b0;
    case (fn_q)
      FN_MUL, FN_MULU, FN_MULSU: res_c = prod;
      FN_DIV, FN_DIVU, FN_REM, FN_REMU: begin
`ifdef RISCV_MULDIV_DIV_EN
        res_c = {r, q};
`else
        err_c = 1'b1;
`endif
      end
      default: err_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v_q   <= '0;
      fn_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      err_q <= '0;
    end else begin
      v_q <= flush ? '0 : v_d;
      if (accept) begin
        fn_q <= muldivreq_msg_fn;
        a_q  <= muldivreq_msg_a;
        b_q  <= muldivreq_msg_b;
      end
      if ((!v_q[1] || adv[1]) && v_q[0]) begin
        res_q[1] <= res_c;
        err_q[1] <= err_c;
      end
      for (int i = 2; i < STAGES; i++) begin
        if ((!v_q[i] || adv[i]) && v_q[i-1]) begin
          res_q[i] <= res_q[i-1];
          err_q[i] <= err_q[i-1];
        end
      end
    end
  end

  assign muldivresp_msg_result = res_q[STAGES-1];
  assign muldivresp_err        = err_q[STAGES-1];
  assign muldivresp_val        = v_q[STAGES-1];

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++)
      occupancy = occupancy + OW'(v_q[i]);
  end

endmodule

// File: tb/tb_riscv_core_dpath_pipe_muldiv_param.sv
// tb/tb_riscv_core_dpath_pipe_muldiv_param.sv - randomized bench against a queue-based reference model
module tb_riscv_core_dpath_pipe_muldiv_param;

  localparam int S = 4;
  localparam logic [2:0] F_MUL = 3'd0, F_DIV = 3'd1, F_DIVU = 3'd2, F_REM = 3'd3,
                         F_REMU = 3'd4, F_MULU = 3'd5, F_MULSU = 3'd6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  fn = '0;
  logic [31:0] a = '0, b = '0;
  logic        req_val = 1'b0, req_rdy;
  logic [63:0] result;
  logic        err, resp_val;
  logic        resp_rdy = 1'b1, flush = 1'b0;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { logic [2:0] fn; logic [31:0] a; logic [31:0] b; } req_t;
  typedef struct { logic [63:0] res; logic err; int acc; } exp_t;
  req_t pend[$];
  exp_t expq[$];

  always #5 clk = ~clk;

  riscv_core_dpath_pipe_muldiv_param #(.W(32), .STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n),
    .muldivreq_msg_fn(fn), .muldivreq_msg_a(a), .muldivreq_msg_b(b),
    .muldivreq_val(req_val), .muldivreq_rdy(req_rdy),
    .muldivresp_msg_result(result), .muldivresp_err(err),
    .muldivresp_val(resp_val), .muldivresp_rdy(resp_rdy),
    .flush(flush), .occupancy(occupancy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Returns {err, result} from the arithmetic rules, using native 64-bit math.
  function automatic logic [64:0] ref_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    int q, r;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    ux = longint'({32'h0, x});
    uy = longint'({32'h0, y});
    case (f)
      F_MUL:   return {1'b0, 64'(sx * sy)};
      F_MULU:  return {1'b0, 64'(ux * uy)};
      F_MULSU: return {1'b0, 64'(sx * uy)};
`ifdef RISCV_MULDIV_DIV_EN
      F_DIV, F_REM: begin
        if (y == 32'h0) return {1'b0, x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'h0, x};
        q = signed'(x) / signed'(y);
        r = signed'(x) % signed'(y);
        return {1'b0, 32'(r), 32'(q)};
      end
      F_DIVU, F_REMU: begin
        if (y == 32'h0) return {1'b0, x, 32'hFFFF_FFFF};
        return {1'b0, x % y, x / y};
      end
`endif
      default: return {1'b1, 64'h0};
    endcase
  endfunction

  task automatic push(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    req_t t;
    t.fn = f; t.a = x; t.b = y;
    pend.push_back(t);
  endtask

  // One clock cycle: drive, check outputs against the model, then commit the model.
  task automatic tick(input bit vin, input bit rr, input bit fl, input bit rst);
    bit hv, exp_rdy, acc, fire;
    logic [64:0] m;
    exp_t e;
    @(negedge clk);
    reset_n  = !rst;
    flush    = fl;
    resp_rdy = rr;
    req_val  = vin && (pend.size() > 0);
    if (req_val) begin
      fn = pend[0].fn; a = pend[0].a; b = pend[0].b;
    end else begin
      fn = 3'($urandom); a = $urandom; b = $urandom;
    end
    #1;
    hv      = (expq.size() > 0) && (cyc - expq[0].acc >= S - 1);
    exp_rdy = !fl && ((expq.size() < S) || rr);
    if (!rst) begin
      check("resp_val", 64'(resp_val), 64'(hv));
      check("occupancy", 64'(occupancy), 64'(expq.size()));
      check("req_rdy", 64'(req_rdy), 64'(exp_rdy));
      if (hv) begin
        check("result", result, expq[0].res);
        check("err", 64'(err), 64'(expq[0].err));
      end
    end
    acc  = req_val && exp_rdy && !rst;
    fire = hv && rr && !fl;
    if (rst || fl) expq.delete();
    else if (fire) void'(expq.pop_front());
    if (acc) begin
      m = ref_op(pend[0].fn, pend[0].a, pend[0].b);
      e.res = m[63:0]; e.err = m[64]; e.acc = cyc + 1;
      expq.push_back(e);
      void'(pend.pop_front());
    end
    cyc++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pend.size() > 0 || expq.size() > 0) && n < 80) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      n++;
    end
    check("drain_done", 64'(pend.size() + expq.size()), 64'h0);
    pend.delete();
    expq.delete();
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("rst_result", result, 64'h0);
    check("rst_err", 64'(err), 64'h0);

    push(F_MUL, -32'sd3, 32'd7);
    push(F_MULSU, 32'hFFFF_FFFF, 32'd2);
    push(F_MULU, 32'hFFFF_FFFF, 32'd2);
    push(F_DIV, -32'sd7, 32'd2);
    push(F_DIVU, 32'd5, 32'd0);
    push(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    push(F_DIVU, 32'd10, 32'd3);
    push(F_REM, -32'sd7, 32'd2);
    push(3'd7, 32'd1, 32'd1);
    drain();

    for (int i = 1; i <= 6; i++) push(F_MUL, 32'(i), 32'(i));
    repeat (6) tick(1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    repeat (3) push(F_MULU, $urandom, $urandom);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    push(F_MUL, 32'd12, 32'd12);
    drain();

    repeat (3) push(F_DIV, $urandom, 32'd3);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    pend.delete();
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 600; i++) begin
      if (pend.size() < 3) push(3'($urandom), rnd_word(), rnd_word());
      tick(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 40) == 0, ($urandom % 150) == 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
